// File: rtl/spi_axis_frame_sched.sv
// Two-channel frame scheduler: pulls whole frames from two FWFT FIFOs and emits
// header + FRAME_LEN data beats on one AXI4-Stream master, round-robin per frame.
module spi_axis_frame_sched #(
    parameter int          DATA_WIDTH = 32,
    parameter int          KEEP_WIDTH = 1,
    parameter int          FRAME_LEN  = 512,
    parameter int          CNT_WIDTH  = 10,
    parameter int          LVL_WIDTH  = 11,
    parameter logic [7:0]  HDR_TAG    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_L,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic [LVL_WIDTH-1:0]  s0_level,
    output logic                  o_s0_rd_en,
    input  logic [DATA_WIDTH-1:0] s1_data,
    input  logic [LVL_WIDTH-1:0]  s1_level,
    output logic                  o_s1_rd_en,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  o_grant,
    output logic                  o_busy,
    output logic [31:0]           o_frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } state_t;

    localparam logic [LVL_WIDTH-1:0] FRAME_LVL = LVL_WIDTH'(FRAME_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(FRAME_LEN - 1);

    state_t                state_q;
    logic                  tvalid_q;
    logic                  grant_q;
    logic                  rr_q;
    logic [15:0]           seq0_q;
    logic [15:0]           seq1_q;
    logic [CNT_WIDTH-1:0]  beat_q;
    logic [31:0]           frame_cnt_q;

    logic                  elig0;
    logic                  elig1;
    logic                  pick_valid;
    logic                  pick_ch;
    logic                  is_last;
    logic [15:0]           hdr_seq;
    logic [31:0]           hdr_word;

    // A channel may start only when its FIFO already holds the whole frame.
    assign elig0      = (s0_level >= FRAME_LVL);
    assign elig1      = (s1_level >= FRAME_LVL);
    assign pick_valid = elig0 | elig1;
    assign pick_ch    = (elig0 & elig1) ? ~rr_q : elig1;

    assign is_last  = (state_q == ST_DATA) && (beat_q == LAST_BEAT);
    assign hdr_seq  = grant_q ? seq1_q : seq0_q;
    assign hdr_word = {HDR_TAG, 7'd0, grant_q, hdr_seq};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        m_axis_tdata = '0;
        if (state_q == ST_DATA) begin
            m_axis_tdata = grant_q ? s1_data : s0_data;
        end else if (state_q == ST_HDR) begin
            m_axis_tdata = DATA_WIDTH'(hdr_word);
        end
    end

    // Pops follow tready directly so the FWFT head advances on each accepted beat.
    assign o_s0_rd_en    = (state_q == ST_DATA) && !grant_q && m_axis_tready;
    assign o_s1_rd_en    = (state_q == ST_DATA) &&  grant_q && m_axis_tready;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = is_last;
    assign m_axis_tkeep  = '1;
    assign o_grant       = grant_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_frame_cnt   = frame_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= ST_IDLE;
            tvalid_q    <= 1'b0;
            grant_q     <= 1'b0;
            rr_q        <= 1'b1;
            seq0_q      <= '0;
            seq1_q      <= '0;
            beat_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_enable && pick_valid) begin
                        grant_q  <= pick_ch;
                        tvalid_q <= 1'b1;
                        state_q  <= ST_HDR;
                        if (elig0 && elig1) begin
                            rr_q <= pick_ch;
                        end
                    end
                end
                ST_HDR: begin
                    if (m_axis_tready) begin
                        beat_q  <= '0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m_axis_tready) begin
                        beat_q <= beat_q + CNT_WIDTH'(1);
                        if (is_last) begin
                            if (grant_q) begin
                                seq1_q <= seq1_q + 16'd1;
                            end else begin
                                seq0_q <= seq0_q + 16'd1;
                            end
                            frame_cnt_q <= frame_cnt_q + 32'd1;
                            tvalid_q    <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tvalid_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_axis_frame_sched.sv
// Bench for spi_axis_frame_sched: FIFO queues plus a frame-level reference model,
// directed scenarios followed by a randomized run.
module tb_spi_axis_frame_sched;

    localparam int DW = 32;
    localparam int KW = 1;
    localparam int FL = 4;
    localparam int CW = 3;
    localparam int LW = 11;

    logic          clk;
    logic          rst_L;
    logic          i_enable;
    logic [DW-1:0] s0_data;
    logic [LW-1:0] s0_level;
    logic          o_s0_rd_en;
    logic [DW-1:0] s1_data;
    logic [LW-1:0] s1_level;
    logic          o_s1_rd_en;
    logic          m_axis_tready;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          o_grant;
    logic          o_busy;
    logic [31:0]   o_frame_cnt;

    spi_axis_frame_sched #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .FRAME_LEN(FL),
        .CNT_WIDTH(CW), .LVL_WIDTH(LW), .HDR_TAG(8'hA5)
    ) dut (
        .clk(clk), .rst_L(rst_L), .i_enable(i_enable),
        .s0_data(s0_data), .s0_level(s0_level), .o_s0_rd_en(o_s0_rd_en),
        .s1_data(s1_data), .s1_level(s1_level), .o_s1_rd_en(o_s1_rd_en),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .o_grant(o_grant), .o_busy(o_busy),
        .o_frame_cnt(o_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] hdr_log[$];

    int n_checks = 0;
    int n_pass   = 0;
    int obs_pops0, obs_pops1, obs_hs, obs_valid;

    // Reference model: one frame in flight, its channel, the beat index and the arbitration history.
    bit          m_active, m_in_data, m_ch, m_rr;
    int          m_beat;
    logic [15:0] m_seq[2];
    logic [31:0] m_frames;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_active = 0; m_in_data = 0; m_ch = 0; m_rr = 1; m_beat = 0;
        m_seq[0] = '0; m_seq[1] = '0; m_frames = '0;
    endtask

    task automatic push(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            if (ch == 0) q0.push_back($urandom());
            else         q1.push_back($urandom());
        end
    endtask

    // One clock: drive FIFO view at the negedge, check mid-cycle, advance model after the posedge.
    task automatic step();
        int lv0, lv1;
        logic [DW-1:0] exp_data;
        bit exp_rd0, exp_rd1, exp_last, e0, e1;
        lv0 = q0.size();
        lv1 = q1.size();
        s0_level = LW'(lv0);
        s1_level = LW'(lv1);
        s0_data  = (lv0 > 0) ? q0[0] : 32'h0BAD_0000;
        s1_data  = (lv1 > 0) ? q1[0] : 32'h0BAD_0001;
        #1;
        exp_rd0 = m_active && m_in_data && (m_ch == 1'b0) && m_axis_tready;
        exp_rd1 = m_active && m_in_data && (m_ch == 1'b1) && m_axis_tready;
        check("tvalid", m_axis_tvalid, m_active);
        check("busy", o_busy, m_active);
        check("grant", o_grant, m_ch);
        check("frame_cnt", o_frame_cnt, m_frames);
        check("rd_en0", o_s0_rd_en, exp_rd0);
        check("rd_en1", o_s1_rd_en, exp_rd1);
        if (m_active) begin
            if (!m_in_data) begin
                exp_data = {8'hA5, 7'd0, m_ch, m_seq[m_ch]};
                exp_last = 0;
            end else begin
                exp_data = m_ch ? q1[0] : q0[0];
                exp_last = (m_beat == FL - 1);
            end
            check("tdata", m_axis_tdata, exp_data);
            check("tlast", m_axis_tlast, exp_last);
            if (!m_in_data && m_axis_tready) hdr_log.push_back(m_axis_tdata);
        end
        obs_pops0 += int'(o_s0_rd_en);
        obs_pops1 += int'(o_s1_rd_en);
        obs_hs    += int'(m_axis_tvalid && m_axis_tready);
        obs_valid += int'(m_axis_tvalid);
        @(posedge clk);
        if (m_active) begin
            if (m_axis_tready) begin
                if (!m_in_data) begin
                    m_in_data = 1;
                    m_beat = 0;
                end else begin
                    if (m_ch) void'(q1.pop_front());
                    else      void'(q0.pop_front());
                    if (m_beat == FL - 1) begin
                        m_seq[m_ch] = m_seq[m_ch] + 16'd1;
                        m_frames = m_frames + 32'd1;
                        m_active = 0;
                        m_in_data = 0;
                    end else begin
                        m_beat++;
                    end
                end
            end
        end else if (i_enable) begin
            e0 = (lv0 >= FL);
            e1 = (lv1 >= FL);
            if (e0 && e1) begin
                m_ch = ~m_rr;
                m_rr = m_ch;
                m_active = 1;
            end else if (e0 || e1) begin
                m_ch = e1;
                m_active = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_counts();
        obs_pops0 = 0; obs_pops1 = 0; obs_hs = 0; obs_valid = 0;
    endtask

    initial begin
        rst_L = 1'b0; i_enable = 1'b0; m_axis_tready = 1'b0;
        s0_data = '0; s1_data = '0; s0_level = '0; s1_level = '0;
        model_reset();
        clear_counts();
        #3;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", o_busy, 0);
        check("rst_grant", o_grant, 0);
        check("rst_frame_cnt", o_frame_cnt, 0);
        check("rst_tkeep", m_axis_tkeep, 1);
        @(negedge clk);
        rst_L = 1'b1;

        // Single eligible channel, two back-to-back frames, full throughput.
        i_enable = 1; m_axis_tready = 1;
        push(0, FL);
        for (int i = 0; i < 10; i++) step();
        check("t1_pops0", obs_pops0, FL);
        check("t1_frames", o_frame_cnt, 1);
        push(0, FL);
        for (int i = 0; i < 10; i++) step();
        check("t1_hdr0", hdr_log[0], 32'hA500_0000);
        check("t1_hdr1", hdr_log[1], 32'hA500_0001);

        // Both channels eligible: grants alternate.
        hdr_log.delete();
        push(0, 2 * FL);
        push(1, 2 * FL);
        for (int i = 0; i < 30; i++) step();
        check("t2_nhdr", hdr_log.size(), 4);
        check("t2_hdr0", hdr_log[0], 32'hA500_0002);
        check("t2_hdr1", hdr_log[1], 32'hA501_0000);
        check("t2_hdr2", hdr_log[2], 32'hA500_0003);
        check("t2_hdr3", hdr_log[3], 32'hA501_0001);

        // Toggling tready: stalls hold data, five handshakes per frame.
        clear_counts();
        push(0, FL);
        for (int i = 0; i < 20; i++) begin
            m_axis_tready = (i % 2 == 0);
            step();
        end
        check("t3_handshakes", obs_hs, FL + 1);
        check("t3_pops0", obs_pops0, FL);
        m_axis_tready = 1;

        // Level one short of a frame must not start anything.
        clear_counts();
        hdr_log.delete();
        push(0, FL - 1);
        for (int i = 0; i < 6; i++) step();
        check("t4_no_valid", obs_valid, 0);
        push(0, 1);
        step();
        check("t4_hdr_valid", m_axis_tvalid, 1);
        for (int i = 0; i < 8; i++) step();
        check("t4_hdr", hdr_log[0], 32'hA500_0005);

        // Enable dropped mid-frame: frame completes, nothing new starts.
        push(0, FL);
        push(1, FL);
        for (int i = 0; i < 20 && !(m_in_data && m_beat == 2); i++) step();
        check("t5_mid_frame", o_busy, 1);
        i_enable = 0;
        for (int i = 0; i < 12; i++) step();
        check("t5_frames", o_frame_cnt, 9);
        check("t5_idle", o_busy, 0);

        // Reset mid-data aborts the frame; seq wrap after reset.
        i_enable = 1;
        push(0, FL);
        for (int i = 0; i < 20 && !(m_in_data && m_beat == 1); i++) step();
        check("t6_busy_before_rst", o_busy, 1);
        rst_L = 0;
        #1;
        check("t6_rst_tvalid", m_axis_tvalid, 0);
        check("t6_rst_rd0", o_s0_rd_en, 0);
        check("t6_rst_rd1", o_s1_rd_en, 0);
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_frames", o_frame_cnt, 0);
        model_reset();
        hdr_log.delete();
        @(negedge clk);
        rst_L = 1;
        while (q1.size() < FL) push(1, 1);
        push(0, FL);
        force dut.seq0_q = 16'hFFFF;
        #1;
        release dut.seq0_q;
        m_seq[0] = 16'hFFFF;
        for (int i = 0; i < 30; i++) step();
        check("t6_nhdr", hdr_log.size(), 3);
        check("t6_hdr0", hdr_log[0], 32'hA500_FFFF);
        check("t6_hdr1", hdr_log[1], 32'hA501_0000);
        check("t6_hdr2", hdr_log[2], 32'hA500_0000);
        check("t6_frames", o_frame_cnt, 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            i_enable      = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 2) == 0 && q0.size() < 20) push(0, 1);
            if ($urandom_range(0, 2) == 0 && q1.size() < 20) push(1, 1);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_axis_frame_sched.md
Name: spi_axis_frame_sched

Overview:
Two-channel frame scheduler in front of the AXI-stream DMA path. It takes words from two FWFT FIFOs, each filled by an SPI-to-AXI bridge channel, and emits whole frames on one AXI4-Stream master. Each frame is one header beat followed by FRAME_LEN data beats. Channel grant is round-robin at frame granularity, and a frame starts only when the granted FIFO already holds the full frame, so the output never underflows mid-frame.

Parameters:
DATA_WIDTH, 32, stream/FIFO word width; must be >=32.
KEEP_WIDTH, 1, width of m_axis_tkeep.
FRAME_LEN, 512, data beats per frame (>=1).
CNT_WIDTH, 10, beat counter width; must satisfy 2^CNT_WIDTH > FRAME_LEN-1.
LVL_WIDTH, 11, FIFO occupancy width.
HDR_TAG, 8'hA5, tag byte placed in the header.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst_L  in  1  asynchronous active-low reset.
i_enable  in  1  scheduler enable; sampled only in IDLE.
s0_data  in  DATA_WIDTH  channel 0 FWFT FIFO head word.
s0_level  in  LVL_WIDTH  channel 0 FIFO occupancy.
o_s0_rd_en  out  1  channel 0 FIFO pop.
s1_data  in  DATA_WIDTH  channel 1 FWFT FIFO head word.
s1_level  in  LVL_WIDTH  channel 1 FIFO occupancy.
o_s1_rd_en  out  1  channel 1 FIFO pop.
m_axis_tready  in  1  downstream ready.
m_axis_tvalid  out  1  stream valid.
m_axis_tdata  out  DATA_WIDTH  stream data.
m_axis_tkeep  out  KEEP_WIDTH  always all ones.
m_axis_tlast  out  1  last beat of frame.
o_grant  out  1  channel currently or last granted.
o_busy  out  1  high in HDR or DATA.
o_frame_cnt  out  32  total frames completed; wraps.

Behaviour:
- Reset (async assert, sync release). State=IDLE, tvalid=0, tlast=0, rd_en=0, o_grant=0, o_busy=0, o_frame_cnt=0, both seq counters=0, beat counter=0, rr pointer=1 (so ch0 wins first tie). A reset asserted mid-frame aborts the frame immediately; no completion, no FIFO pops.
- Eligibility. chN eligible when sN_level >= FRAME_LEN. The comparison is unsigned and level == FRAME_LEN counts as eligible.
- IDLE. If i_enable=1 and at least one channel is eligible, register a grant and go to HDR on the next edge.
  - Only one eligible: grant it.
  - Both eligible: grant the channel != rr pointer, then set rr pointer = granted channel.
  - Grant decision costs 1 cycle (IDLE→HDR).
- HDR. tvalid=1; tdata = {HDR_TAG, 7'b0, grant, seq[grant][15:0]}, upper bits above 32 zero; tlast=0.
  - Header is held stable until tready.
  - On handshake: go to DATA with beat counter=0.
- DATA. tvalid=1; tdata = granted sN_data, combinational from the FWFT head; o_sN_rd_en(grant) = tready; the other rd_en = 0.
  - Each handshake increments the beat counter.
  - tlast = (beat counter == FRAME_LEN-1).
  - On the tlast handshake: seq[grant] += 1 (16-bit wrap 0xFFFF→0), o_frame_cnt += 1, go to IDLE.
  - At least one IDLE cycle occurs between frames.
- rd_en is never asserted outside DATA or without tready. Exactly FRAME_LEN pops occur per frame.
- AXIS rules:
  - tvalid never drops without a handshake.
  - tdata and tlast are stable while tvalid=1 and tready=0.
  - tready may toggle every cycle.
- i_enable deasserted mid-frame: the frame completes; no new grant is made afterwards.
- Level rising during a frame has no effect. Level is not re-checked mid-frame; upstream guarantees no external pops.
- o_busy = (state != IDLE). o_grant holds its value in IDLE.

Test Plan:
1. FRAME_LEN=4, s0_level=4, s1_level=0, i_enable=1, tready=1 → header 0xA500_0000, then s0 words D0..D3 with tlast on D3; o_s0_rd_en high exactly 4 cycles; o_frame_cnt=1; next ch0 header 0xA500_0001.
2. Both levels >=4 continuously → grants alternate ch0, ch1, ch0, ch1; ch1 first header 0xA501_0000.
3. tready toggled 1,0,1,0 during a frame → tdata/tlast held on stalled cycles; no pop when tready=0; 5 handshakes total.
4. s0_level=3 (FRAME_LEN-1) → stays IDLE, tvalid=0; raise to 4 → header appears 1 cycle after next edge.
5. i_enable drops on data beat 2 → frame finishes with tlast; then IDLE despite eligible FIFOs.
6. rst_L low mid-DATA → tvalid, rd_en, o_busy=0 immediately; o_frame_cnt=0; first post-reset grant is ch0; also force seq=0xFFFF → next header seq 0x0000.
